// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the unified-memory arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE=0, DATA=1, FETCH=2)
//   cnt_width() : width of a counter that must hold 0..limit inclusive
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StData  = 2'd1,
        StFetch = 2'd2
    } arb_state_e;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// mem_arbiter_starve_counter
// Saturating fetch-starvation counter used by the arbiter fairness option.
// Only elaborated when MEM_ARB_FAIRNESS_EN is defined, matching its single
// instantiation site in mem_arbiter.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (count -> 0)
//   inc      in   increment request (saturates at LIMIT)
//   clr      in   clear request (wins over inc)
//   at_limit out  count == LIMIT
// -----------------------------------------------------------------------------
`ifdef MEM_ARB_FAIRNESS_EN
module mem_arbiter_starve_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned W = cnt_width(LIMIT);
    localparam logic [W-1:0] MaxCnt = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == MaxCnt);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port unified memory between instruction fetch (read-only)
// and the MEM stage (read/write). Data wins over fetch because the MEM-stage
// instruction is older. Produces per-requester done/stall and quiesces fetch
// on halt.
//
// Optional feature: define MEM_ARB_FAIRNESS_EN to force a fetch grant after
// STARVE_LIMIT consecutive data grants taken while fetch was waiting.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   if_req/if_addr       fetch request (held until if_done) and PC
//   if_rdata/if_done     fetch data and one-cycle completion pulse
//   if_stall             if_req & ~if_done
//   mem_rd/mem_wr        data read/write request (held until mem_done)
//   mem_addr/mem_wdata   data address and store data
//   mem_rdata/mem_done   load data and one-cycle completion pulse
//   mem_stall            (mem_rd|mem_wr) & ~mem_done
//   halt/halted          halt control; halt seen with arbiter idle (registered)
//   req_err              sticky: mem_rd and mem_wr seen together
//   m_en/m_wr            memory command strobe and write qualifier
//   m_addr/m_wdata       memory address / write data, held until m_done
//   m_busy               memory cannot accept a command
//   m_done/m_rdata       memory completion pulse and read data
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    input  logic              halt,
    output logic              halted,
    output logic              req_err,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_busy,
    input  logic              m_done,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e        state_q, state_d;
    logic              m_wr_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic              halted_q;
    logic              req_err_q;

    logic data_req;
    logic fetch_ok;
    logic force_fetch;
    logic issue_data;
    logic issue_fetch;

    assign data_req = mem_rd | mem_wr;
    assign fetch_ok = if_req & ~halt;

`ifdef MEM_ARB_FAIRNESS_EN
    logic starve_at_limit;

    // Counts data grants that bypassed a waiting fetch.
    mem_arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (issue_data & if_req),
        .clr      (issue_fetch),
        .at_limit (starve_at_limit)
    );

    assign force_fetch = starve_at_limit;
`else
    // STARVE_LIMIT only matters with the fairness option.
    logic unused_starve_limit;
    assign unused_starve_limit = |STARVE_LIMIT;
    assign force_fetch         = 1'b0;
`endif

    // Next state and command/done decode. Everything is gated by rst so that
    // the in-flight response is dropped and no command leaks out in reset.
    always_comb begin
        state_d     = state_q;
        issue_data  = 1'b0;
        issue_fetch = 1'b0;
        if_done     = 1'b0;
        mem_done    = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle: begin
                    if (!m_busy) begin
                        if (data_req && !(force_fetch && fetch_ok)) begin
                            issue_data = 1'b1;
                            state_d    = StData;
                        end else if (fetch_ok) begin
                            issue_fetch = 1'b1;
                            state_d     = StFetch;
                        end
                    end
                end
                StData: begin
                    if (m_done) begin
                        mem_done = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StFetch: begin
                    if (m_done) begin
                        if_done = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Command goes out combinationally in the issue cycle, then the captured
    // copy holds the bus stable until m_done. A rd+wr collision is a write.
    always_comb begin
        m_wr    = m_wr_q;
        m_addr  = m_addr_q;
        m_wdata = m_wdata_q;
        if (issue_data) begin
            m_wr    = mem_wr;
            m_addr  = mem_addr;
            m_wdata = mem_wdata;
        end else if (issue_fetch) begin
            m_wr   = 1'b0;
            m_addr = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            halted_q  <= 1'b0;
            req_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue_data || issue_fetch) begin
                m_wr_q    <= m_wr;
                m_addr_q  <= m_addr;
                m_wdata_q <= m_wdata;
            end
            halted_q  <= halt & (state_q == StIdle) & ~data_req;
            req_err_q <= req_err_q | (mem_rd & mem_wr);
        end
    end

    assign m_en      = issue_data | issue_fetch;
    assign if_rdata  = if_done ? m_rdata : '0;
    assign mem_rdata = mem_done ? m_rdata : '0;
    assign if_stall  = if_req & ~if_done;
    assign mem_stall = data_req & ~mem_done;
    assign halted    = halted_q;
    assign req_err   = req_err_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single unified single-port memory of the 16-bit pipelined processor between two requesters: instruction fetch (IF, read-only) and the MEM stage (read/write).
- The MEM-stage request originates from the decoded MemEN/MemRead/MemWrite controls.
- Owns the memory-side handshake and generates per-requester done and stall signals that freeze the pipeline while an access is outstanding.
- Also quiesces fetch on Halt.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- STARVE_LIMIT, 4, number of consecutive fetch denials before fetch gets forced priority (used only with MEM_ARB_FAIRNESS_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held until if_done
- if_addr  input  ADDR_W  fetch address (PC)
- if_rdata  output  DATA_W  fetch data, valid when if_done
- if_done  output  1  one-cycle fetch completion pulse
- if_stall  output  1  if_req & ~if_done
- mem_rd  input  1  data read request (MemEN & MemRead); held until mem_done
- mem_wr  input  1  data write request (MemEN & MemWrite); held until mem_done
- mem_addr  input  ADDR_W  data address
- mem_wdata  input  DATA_W  store data
- mem_rdata  output  DATA_W  load data, valid when mem_done
- mem_done  output  1  one-cycle data completion pulse
- mem_stall  output  1  (mem_rd|mem_wr) & ~mem_done
- halt  input  1  Halt control from the pipeline
- halted  output  1  halt seen and arbiter idle
- req_err  output  1  sticky: mem_rd and mem_wr asserted together
- m_en  output  1  memory command strobe, one cycle
- m_wr  output  1  write qualifier for m_en
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_busy  input  1  memory cannot accept a command
- m_done  input  1  memory completion pulse
- m_rdata  input  DATA_W  memory read data, valid with m_done

Behaviour:
- FSM states IDLE, DATA, FETCH.
- Reset: state=IDLE. All outputs 0; req_err=0; starvation count=0.
- IDLE: if ~m_busy and (mem_rd|mem_wr), then pulse m_en with m_wr=mem_wr and m_addr/m_wdata from the data port, and go to DATA.
- Otherwise, if ~m_busy, if_req and ~halt, then pulse m_en with m_wr=0 and m_addr=if_addr, and go to FETCH.
- Otherwise stay in IDLE.
- Priority: data over fetch, because the MEM-stage instruction is older and this avoids deadlock.
- Command signals m_addr/m_wr/m_wdata are registered in the command cycle and held stable until m_done.
- DATA: on m_done, mem_done=1 in the same cycle, mem_rdata=m_rdata (combinational pass-through), then go to IDLE.
- FETCH: on m_done, if_done=1 in the same cycle, if_rdata=m_rdata, then go to IDLE.
- Latency: command issued in the cycle a request is seen in IDLE; done equals memory latency; minimum 1 idle bubble between back-to-back accesses (the done cycle returns to IDLE, and the next issue is the following cycle).
- mem_rd & mem_wr together: treated as a write; req_err is set and is sticky until rst.
- m_done in IDLE: ignored.
- Request deasserted before done: the access completes anyway and the done pulse is still generated; the requester must keep its request stable (protocol violation, not checked).
- m_busy high in IDLE: no issue; stall outputs stay asserted.
- rst mid-access: state returns to IDLE and the in-flight response is dropped; memory shares rst.
- halt: blocks new fetch grants and in-flight accesses complete. Data requests are still served. halted = halt & (state==IDLE) & ~(mem_rd|mem_wr), registered (1-cycle lag).

Optional Feature:
- MEM_ARB_FAIRNESS_EN defined:
  - A counter increments each IDLE issue where data wins while if_req is pending, and clears on any fetch grant.
  - When count==STARVE_LIMIT, the next IDLE issue goes to fetch even if a data request is present.
- Undefined: strict data priority, no counter logic.

Decomposition:
- Shared include mem_arb_defs.vh holds the state encodings (IDLE=2'd0, DATA=2'd1, FETCH=2'd2).
- Widths come from parameters.
- One natural sub-module: starve_counter (saturating counter with clear and limit flag), instantiated only under MEM_ARB_FAIRNESS_EN.
- State registers use the existing dff cell.

Test Plan:
- Reset: hold rst 2 cycles with if_req=1 -> m_en, if_done, mem_done, halted, req_err all 0. First m_en is in the first cycle after rst falls.
- Single fetch: if_addr=16'h0010, memory latency 3, m_rdata=16'hA5A5 -> m_en pulse with m_wr=0, m_addr=16'h0010. if_done occurs 3 cycles later with if_rdata=16'hA5A5. if_stall is high until then.
- Contention: if_req and mem_wr (addr 16'h0200, data 16'h1234) asserted in the same cycle -> the write is issued first (m_wr=1). The fetch is issued 1 cycle after mem_done.
- Error: mem_rd=mem_wr=1 -> a write is performed and req_err is set and stays 1 until rst.
- Halt: halt=1 during a fetch in flight -> the fetch completes and no further fetch is issued. halted=1 one cycle after IDLE.
- Fairness (macro on, STARVE_LIMIT=4): continuous data requests plus if_req -> 4 data grants, then 1 fetch grant, repeating. With the macro off, fetch never issues.
